// File: rtl/hiscore_arb_pkg.sv
// Shared types and helpers for the hiscore RAM arbiter.
//   arb_state_e : arbiter FSM states
//   cnt_width   : width of the shared phase counter, sized to the largest phase length
package hiscore_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    SYNC,
    GRANT,
    RELEASE
  } arb_state_e;

  // Width able to hold the largest of the three phase lengths.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/arb_downcounter.sv
// Loadable saturating down-counter with zero flag.
//   clk, rst     : clock, asynchronous active-high reset
//   i_load       : load i_load_val (has priority over decrement)
//   i_dec        : decrement by one, holding at zero
//   o_zero       : counter value is zero
module arb_downcounter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Count register: load wins, otherwise step down and stick at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Shares the game work-RAM port between the core CPU and the hiscore engine.
// A hiscore request pauses the core, waits for the CPU to settle and for a vblank
// rising edge (or a timeout), then hands the RAM port over. When the request drops
// the port returns to the CPU and the pause is held for a short holdoff.
//   clk_sys, reset          : clock, asynchronous active-high reset
//   vblank                  : core vertical blank
//   hs_req/addr/wdata/we/rd : hiscore request level and RAM strobes
//   hs_grant                : port owned by hiscore
//   hs_rdata, hs_rvalid     : read data and its one-cycle valid pulse
//   cpu_addr/wdata/we       : CPU side of the RAM port
//   ram_addr/wdata/we/rdata : RAM port (1-cycle synchronous read)
//   pause_req               : core pause request
//   sync_timeout            : sticky flag, last grant was forced by timeout
module hiscore_ram_arbiter
  import hiscore_arb_pkg::*;
#(
  parameter int unsigned AW           = 11,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter bit          SYNC_VBL     = 1'b1,
  parameter int unsigned SYNC_TIMEOUT = 500000,
  parameter int unsigned HOLDOFF_CYC  = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          vblank,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic [7:0]    hs_wdata,
  input  logic          hs_we,
  input  logic          hs_rd,
  output logic          hs_grant,
  output logic [7:0]    hs_rdata,
  output logic          hs_rvalid,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  input  logic          cpu_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  input  logic [7:0]    ram_rdata,
  output logic          pause_req,
  output logic          sync_timeout
);

  localparam int unsigned CW = cnt_width(SETTLE_CYC, SYNC_TIMEOUT, HOLDOFF_CYC);

  // A phase of N cycles loads N-1 and ends on the cycle the counter reads zero.
  localparam logic [CW-1:0] SETTLE_LD  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LD = CW'(SYNC_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLDOFF_LD = CW'(HOLDOFF_CYC - 1);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic          r_grant;
  logic          r_pause;
  logic          r_tmo;
  logic          r_vbl_prev;
  logic          r_rvalid;
  logic [7:0]    r_rdata;

  logic          w_cnt_load;
  logic [CW-1:0] w_cnt_val;
  logic          w_cnt_zero;
  logic          w_tmo_set;
  logic          w_tmo_clr;
  logic          w_vbl_rise;
  logic          w_idle;

  assign w_vbl_rise = vblank & ~r_vbl_prev;
  assign w_idle     = (r_state == IDLE);

  // One counter serves settle, sync timeout and holdoff; it only runs between loads.
  arb_downcounter #(.W(CW)) u_cnt (
    .clk        (clk_sys),
    .rst        (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (~w_cnt_load),
    .o_zero     (w_cnt_zero)
  );

  // Next-state and counter control.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    w_tmo_set   = 1'b0;
    w_tmo_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (hs_req) begin
          w_state_nxt = HALT;
          w_cnt_load  = 1'b1;
          w_cnt_val   = SETTLE_LD;
          w_tmo_clr   = 1'b1;
        end
      end
      HALT: begin
        if (!hs_req) begin
          w_state_nxt = RELEASE;
          w_cnt_load  = 1'b1;
          w_cnt_val   = HOLDOFF_LD;
        end else if (w_cnt_zero) begin
          if (SYNC_VBL) begin
            w_state_nxt = SYNC;
            w_cnt_load  = 1'b1;
            w_cnt_val   = TIMEOUT_LD;
          end else begin
            w_state_nxt = GRANT;
          end
        end
      end
      SYNC: begin
        if (!hs_req) begin
          w_state_nxt = RELEASE;
          w_cnt_load  = 1'b1;
          w_cnt_val   = HOLDOFF_LD;
        end else if (w_vbl_rise) begin
          w_state_nxt = GRANT;
        end else if (w_cnt_zero) begin
          w_state_nxt = GRANT;
          w_tmo_set   = 1'b1;
        end
      end
      GRANT: begin
        if (!hs_req) begin
          w_state_nxt = RELEASE;
          w_cnt_load  = 1'b1;
          w_cnt_val   = HOLDOFF_LD;
        end
      end
      RELEASE: begin
        if (w_cnt_zero) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; grant/pause are decoded from the next state.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= 1'b0;
      r_pause    <= 1'b0;
      r_tmo      <= 1'b0;
      r_vbl_prev <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= (w_state_nxt == GRANT);
      r_pause    <= (w_state_nxt != IDLE);
      r_vbl_prev <= vblank;
      if (w_tmo_clr) begin
        r_tmo <= 1'b0;
      end else if (w_tmo_set) begin
        r_tmo <= 1'b1;
      end
      // Write wins over a simultaneous read.
      r_rvalid <= r_grant & hs_rd & ~hs_we;
      if (r_rvalid) begin
        r_rdata <= ram_rdata;
      end
    end
  end

  // During the valid pulse the RAM's own output register supplies the data;
  // afterwards the captured copy holds it.
  assign hs_rdata     = r_rvalid ? ram_rdata : r_rdata;
  assign hs_rvalid    = r_rvalid;
  assign hs_grant     = r_grant;
  assign pause_req    = r_pause;
  assign sync_timeout = r_tmo;

  // RAM port mux; CPU writes only pass while idle.
  assign ram_addr  = r_grant ? hs_addr  : cpu_addr;
  assign ram_wdata = r_grant ? hs_wdata : cpu_wdata;
  assign ram_we    = r_grant ? hs_we    : (w_idle & cpu_we);

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Bench for hiscore_ram_arbiter: directed sessions with literal expectations,
// then randomized traffic compared every cycle against a timestamp-based model.
module tb_hiscore_ram_arbiter;

  localparam int unsigned AW     = 11;
  localparam int unsigned SETTLE = 16;
  localparam int unsigned TMO    = 100;
  localparam int unsigned HOLD   = 8;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          vblank = 1'b0;
  logic          hs_req = 1'b0;
  logic [AW-1:0] hs_addr = '0;
  logic [7:0]    hs_wdata = 8'h00;
  logic          hs_we = 1'b0;
  logic          hs_rd = 1'b0;
  logic          hs_grant;
  logic [7:0]    hs_rdata;
  logic          hs_rvalid;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = 8'h00;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata = 8'h00;
  logic          pause_req;
  logic          sync_timeout;

  hiscore_ram_arbiter #(
    .AW(AW), .SETTLE_CYC(SETTLE), .SYNC_VBL(1'b1),
    .SYNC_TIMEOUT(TMO), .HOLDOFF_CYC(HOLD)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .vblank(vblank),
    .hs_req(hs_req), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
    .hs_we(hs_we), .hs_rd(hs_rd), .hs_grant(hs_grant),
    .hs_rdata(hs_rdata), .hs_rvalid(hs_rvalid),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .pause_req(pause_req), .sync_timeout(sync_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  // Work RAM: synchronous read, read-before-write.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: phase plus absolute cycle deadlines.
  // Phases: 0 idle, 1 settle, 2 vblank wait, 3 hiscore owns port, 4 holdoff.
  int         m_ph = 0;
  longint     m_cyc = 0;
  longint     m_dl = 0;
  bit         m_vprev = 1'b0;
  bit         m_tmo = 1'b0;
  bit         m_rvalid = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] shadow [0:(1<<AW)-1];

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      if (cpu_we && clk_sys) shadow[cpu_addr] = cpu_wdata;
      m_ph = 0; m_vprev = 1'b0; m_tmo = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00;
    end else begin
      m_rvalid = (m_ph == 3) && hs_rd && !hs_we;
      if (m_rvalid) m_rdata = shadow[hs_addr];
      if (m_ph == 3 && hs_we) shadow[hs_addr] = hs_wdata;
      else if (m_ph == 0 && cpu_we) shadow[cpu_addr] = cpu_wdata;
      case (m_ph)
        0: if (hs_req) begin m_ph = 1; m_dl = m_cyc + SETTLE; m_tmo = 1'b0; end
        1: if (!hs_req) begin m_ph = 4; m_dl = m_cyc + HOLD; end
           else if (m_cyc == m_dl) begin m_ph = 2; m_dl = m_cyc + TMO; end
        2: if (!hs_req) begin m_ph = 4; m_dl = m_cyc + HOLD; end
           else if (vblank && !m_vprev) m_ph = 3;
           else if (m_cyc == m_dl) begin m_ph = 3; m_tmo = 1'b1; end
        3: if (!hs_req) begin m_ph = 4; m_dl = m_cyc + HOLD; end
        default: if (m_cyc == m_dl) m_ph = 0;
      endcase
      m_vprev = vblank;
    end
    m_cyc++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk_sys) begin
    chk("grant",   32'(hs_grant),     32'(m_ph == 3));
    chk("pause",   32'(pause_req),    32'(m_ph != 0));
    chk("tmo",     32'(sync_timeout), 32'(m_tmo));
    chk("rvalid",  32'(hs_rvalid),    32'(m_rvalid));
    chk("rdata",   32'(hs_rdata),     32'(m_rdata));
    chk("ram_we",  32'(ram_we),
        32'((m_ph == 3) ? hs_we : ((m_ph == 0) ? cpu_we : 1'b0)));
    chk("ram_addr", 32'(ram_addr),  32'((m_ph == 3) ? hs_addr : cpu_addr));
    chk("ram_wdat", 32'(ram_wdata), 32'((m_ph == 3) ? hs_wdata : cpu_wdata));
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  bit saw_grant;
  int vbl_div;

  initial begin
    // Preload the addresses used below through the CPU port while in reset.
    for (int i = 0; i < 32; i++) begin
      step();
      cpu_we = 1'b1; cpu_addr = AW'(i); cpu_wdata = 8'(i * 7 + 3);
    end
    step();
    cpu_we = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_grant",  32'(hs_grant),     32'h0);
    chk("rst_pause",  32'(pause_req),    32'h0);
    chk("rst_tmo",    32'(sync_timeout), 32'h0);
    chk("rst_rvalid", 32'(hs_rvalid),    32'h0);
    chk("rst_rdata",  32'(hs_rdata),     32'h0);

    // Session with vblank rise at cycle 40; CPU writes blocked while paused.
    step(); hs_req = 1'b1;
    @(negedge clk_sys); chk("t1_pause_c0", 32'(pause_req), 32'h0);
    for (int k = 1; k <= 41; k++) begin
      step();
      cpu_we = (k < 40); cpu_addr = AW'(k + 100); cpu_wdata = 8'hEE;
      if (k == 40) vblank = 1'b1;
      @(negedge clk_sys);
      if (k == 1)  chk("t1_pause_c1", 32'(pause_req), 32'h1);
      if (k == 5)  chk("t5_halt_we",  32'(ram_we),    32'h0);
      if (k == 30) chk("t5_sync_we",  32'(ram_we),    32'h0);
      if (k == 40) chk("t1_grant_c40", 32'(hs_grant), 32'h0);
      if (k == 41) chk("t1_grant_c41", 32'(hs_grant), 32'h1);
    end
    // Write then read back through the granted port.
    step();
    hs_we = 1'b1; hs_addr = AW'(11'h010); hs_wdata = 8'h5A;
    cpu_we = 1'b1; cpu_addr = AW'(11'h123);
    @(negedge clk_sys);
    chk("t2_we",    32'(ram_we),    32'h1);
    chk("t2_addr",  32'(ram_addr),  32'h010);
    chk("t2_wdata", 32'(ram_wdata), 32'h5A);
    step(); hs_we = 1'b0; hs_rd = 1'b1;
    @(negedge clk_sys);
    chk("t5_grant_cpu_we", 32'(ram_we), 32'h0);
    chk("t2_rv_c0", 32'(hs_rvalid), 32'h0);
    step(); hs_rd = 1'b0;
    @(negedge clk_sys);
    chk("t2_rv_c1", 32'(hs_rvalid), 32'h1);
    chk("t2_rdata", 32'(hs_rdata),  32'h5A);
    step();
    @(negedge clk_sys);
    chk("t2_rv_c2",   32'(hs_rvalid), 32'h0);
    chk("t2_rd_hold", 32'(hs_rdata),  32'h5A);
    // Read in the last granted cycle is still answered.
    step(); hs_req = 1'b0; hs_rd = 1'b1;
    @(negedge clk_sys); chk("rel_last_grant", 32'(hs_grant), 32'h1);
    step(); hs_rd = 1'b0;
    @(negedge clk_sys);
    chk("rel_grant0", 32'(hs_grant),  32'h0);
    chk("rel_rvalid", 32'(hs_rvalid), 32'h1);
    chk("rel_rdata",  32'(hs_rdata),  32'h5A);
    chk("rel_cpu_we", 32'(ram_we),    32'h0);
    for (int k = 2; k <= 9; k++) begin
      step();
      @(negedge clk_sys);
      if (k == 8) chk("rel_pause_last", 32'(pause_req), 32'h1);
      if (k == 9) chk("rel_pause_off",  32'(pause_req), 32'h0);
      if (k == 9) chk("idle_cpu_we",    32'(ram_we),    32'h1);
    end
    cpu_we = 1'b0;

    // Drop during settle, re-request during holdoff.
    step(); hs_req = 1'b1; saw_grant = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 5)  hs_req = 1'b0;
      if (k == 10) hs_req = 1'b1;
      if (k == 15) hs_req = 1'b0;
      @(negedge clk_sys);
      if (hs_grant) saw_grant = 1'b1;
      if (k == 13) chk("t4_pause_c13", 32'(pause_req), 32'h1);
      if (k == 14) chk("t4_pause_c14", 32'(pause_req), 32'h0);
      if (k == 15) chk("t4_pause_c15", 32'(pause_req), 32'h1);
    end
    chk("t4_no_grant", 32'(saw_grant), 32'h0);
    for (int k = 0; k < 4; k++) step();

    // No vblank edge: forced grant after settle + timeout, flag cleared on next request.
    step(); hs_req = 1'b1;
    for (int k = 1; k <= 152; k++) begin
      step();
      if (k == 118) hs_req = 1'b0;
      if (k == 127) hs_req = 1'b1;
      if (k == 145) vblank = 1'b0;
      if (k == 150) vblank = 1'b1;
      if (k == 152) begin cpu_addr = AW'(11'h7AB); hs_addr = AW'(11'h010); end
      @(negedge clk_sys);
      if (k == 116) chk("t3_grant_c116", 32'(hs_grant), 32'h0);
      if (k == 117) chk("t3_grant_c117", 32'(hs_grant), 32'h1);
      if (k == 117) chk("t3_tmo_set",    32'(sync_timeout), 32'h1);
      if (k == 127) chk("t3_tmo_sticky", 32'(sync_timeout), 32'h1);
      if (k == 128) chk("t3_tmo_clear",  32'(sync_timeout), 32'h0);
      if (k == 151) chk("t6_grant",      32'(hs_grant), 32'h1);
      if (k == 152) chk("t6_addr_hs",    32'(ram_addr), 32'h010);
    end
    // Asynchronous reset mid-grant.
    #1 reset = 1'b1;
    #1;
    chk("t6_grant_rst", 32'(hs_grant),  32'h0);
    chk("t6_pause_rst", 32'(pause_req), 32'h0);
    chk("t6_addr_cpu",  32'(ram_addr),  32'h7AB);
    step(); step();
    reset = 1'b0; hs_req = 1'b0; vblank = 1'b0;

    // Randomized traffic.
    vbl_div = 10;
    for (int i = 0; i < 6000; i++) begin
      step();
      if (i % 600 == 0) vbl_div = ($urandom_range(0, 1) == 0) ? 8 : 150;
      if (hs_req) begin
        if ($urandom_range(0, 79) == 0) hs_req = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        hs_req = 1'b1;
      end
      if ($urandom_range(0, vbl_div) == 0) vblank = ~vblank;
      hs_we     = ($urandom_range(0, 3) == 0);
      hs_rd     = ($urandom_range(0, 2) == 0);
      hs_addr   = AW'($urandom_range(0, 15));
      hs_wdata  = 8'($urandom);
      cpu_we    = ($urandom_range(0, 1) == 0);
      cpu_addr  = AW'($urandom_range(0, 31));
      cpu_wdata = 8'($urandom);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 1499) == 0) reset = 1'b1;
    end
    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
